// File: rtl/rover_enc_pkg.sv
// rover_enc_pkg: register map, CTRL bit positions, ERR saturation value and quadrature phase helper
package rover_enc_pkg;
  localparam logic [1:0] POS_ADDR = 2'd0;
  localparam logic [1:0] VEL_ADDR = 2'd1;
  localparam logic [1:0] ERR_ADDR = 2'd2;
  localparam logic [1:0] CTRL_ADDR = 2'd3;
  localparam int EN_BIT = 0;
  localparam int INV_BIT = 1;
  localparam logic [15:0] ERR_MAX = 16'hFFFF;
  localparam logic [1:0] CTRL_RST = 2'b01;
  typedef enum logic [1:0] {STEP_NONE = 2'd0, STEP_FWD = 2'd1, STEP_ILL = 2'd2, STEP_REV = 2'd3} step_e;
  function automatic logic [1:0] phase(input logic [1:0] ab);
    return {ab[0], ab[1] ^ ab[0]};
  endfunction
endpackage

// File: rtl/enc_glitch_filter.sv
// enc_glitch_filter: 2-FF synchroniser and stable-run filter for one encoder pin (pin_i -> level_o, valid_o after first stable run)
module enc_glitch_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic level_o,
  output logic valid_o
);
  logic [1:0] sync_q;
  logic hold_q, level_q, level_d, valid_q, valid_d;
  logic [3:0] run_q, run_d;
  always_comb begin
    run_d = (sync_q[1] == hold_q) ? ((run_q == 4'(FILTER_LEN)) ? run_q : run_q + 4'd1) : 4'd1;
    level_d = (run_d == 4'(FILTER_LEN)) ? sync_q[1] : level_q;
    valid_d = valid_q | (run_d == 4'(FILTER_LEN));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q <= '0;
      hold_q <= 1'b0;
      run_q <= '0;
      level_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pin_i};
      hold_q <= sync_q[1];
      run_q <= run_d;
      level_q <= level_d;
      valid_q <= valid_d;
    end
  assign level_o = level_q;
  assign valid_o = valid_q;
endmodule

// File: rtl/quad_encoder_if.sv
// quad_encoder_if: x4 quadrature decoder (enc_a/enc_b) with POS/VEL/ERR/CTRL on a 4-word Avalon-MM slave, clk_50 domain
module quad_encoder_if
  import rover_enc_pkg::*;
#(
  parameter int FILTER_LEN = 4,
  parameter int SAMPLE_CYCLES = 500000
) (
  input  logic        clk_50,
  input  logic        reset,
  input  logic        enc_a,
  input  logic        enc_b,
  input  logic [1:0]  avs_address,
  input  logic        avs_read,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  output logic [31:0] avs_readdata
);
  localparam int CW = $clog2(SAMPLE_CYCLES);
  logic a_f, b_f, a_v, b_v, ab_v, live, ill, term;
  logic [1:0] cur, diff, prev_q, prev_d, ctrl_q, ctrl_d;
  logic primed_q, primed_d;
  logic [15:0] err_q, err_d;
  logic [31:0] step, pos_q, pos_d, vel_q, vel_d, acc_q, acc_d, rdata_q, rdata_d;
  logic [CW-1:0] win_q, win_d;
  step_e kind;
  enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_a (
    .clk(clk_50), .rst(reset), .pin_i(enc_a), .level_o(a_f), .valid_o(a_v)
  );
  enc_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filt_b (
    .clk(clk_50), .rst(reset), .pin_i(enc_b), .level_o(b_f), .valid_o(b_v)
  );
  always_comb begin
    cur = {a_f, b_f};
    ab_v = a_v & b_v;
    live = primed_q & ctrl_q[EN_BIT];
    diff = phase(cur) - phase(prev_q);
    kind = step_e'(diff);
    ill = live & (kind == STEP_ILL);
    step = (!live || kind == STEP_NONE || kind == STEP_ILL) ? '0 :
           ((kind == STEP_FWD) ^ ctrl_q[INV_BIT]) ? 32'd1 : '1;
    term = win_q == CW'(SAMPLE_CYCLES - 1);
    primed_d = primed_q | ab_v;
    prev_d = ab_v ? cur : prev_q;
    pos_d = (avs_write && avs_address == POS_ADDR) ? avs_writedata : pos_q + step;
    acc_d = term ? '0 : acc_q + step;
    vel_d = term ? acc_q + step : vel_q;
    win_d = term ? '0 : win_q + CW'(1);
    err_d = (avs_write && avs_address == ERR_ADDR) ? '0 :
            (ill && err_q != ERR_MAX) ? err_q + 16'd1 : err_q;
    ctrl_d = (avs_write && avs_address == CTRL_ADDR) ? avs_writedata[1:0] : ctrl_q;
    rdata_d = !avs_read ? rdata_q :
              (avs_address == POS_ADDR) ? pos_q :
              (avs_address == VEL_ADDR) ? vel_q :
              (avs_address == ERR_ADDR) ? {16'd0, err_q} : {30'd0, ctrl_q};
  end
  always_ff @(posedge clk_50 or posedge reset)
    if (reset) begin
      prev_q <= '0;
      primed_q <= 1'b0;
      pos_q <= '0;
      vel_q <= '0;
      acc_q <= '0;
      win_q <= '0;
      err_q <= '0;
      ctrl_q <= CTRL_RST;
      rdata_q <= '0;
    end else begin
      prev_q <= prev_d;
      primed_q <= primed_d;
      pos_q <= pos_d;
      vel_q <= vel_d;
      acc_q <= acc_d;
      win_q <= win_d;
      err_q <= err_d;
      ctrl_q <= ctrl_d;
      rdata_q <= rdata_d;
    end
  assign avs_readdata = rdata_q;
endmodule
